// File: rtl/imme_gen_pipe.sv
// imme_gen_pipe: ID-stage immediate generator with a LAT-deep register pipeline.
// Forms a WIDTH_I-bit operand from the instruction word in one of six modes and
// carries it to EX with valid/stall/flush control. Reserved modes produce 0 and
// raise mode_err alongside the data.
module imme_gen_pipe #(
    parameter int WIDTH_I = 32,
    parameter int LAT     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               stall,
    input  logic               flush,
    input  logic [31:0]        instr,
    input  logic [WIDTH_I-1:0] pc_plus4,
    input  logic [2:0]         imme_mode,
    output logic               out_valid,
    output logic [WIDTH_I-1:0] imme_out,
    output logic               mode_err
);

    localparam logic [2:0] MODE_SEXT  = 3'd0;
    localparam logic [2:0] MODE_ZEXT  = 3'd1;
    localparam logic [2:0] MODE_LUI   = 3'd2;
    localparam logic [2:0] MODE_BR    = 3'd3;
    localparam logic [2:0] MODE_JMP   = 3'd4;
    localparam logic [2:0] MODE_SHAMT = 3'd5;

    // Reject unsupported pipeline depths and datapath widths at elaboration.
    generate
        if ((LAT != 1) && (LAT != 2)) begin : g_bad_lat
            $error("imme_gen_pipe: LAT must be 1 or 2");
        end
        if (WIDTH_I < 32) begin : g_bad_width
            $error("imme_gen_pipe: WIDTH_I must be at least 32");
        end
    endgenerate

    logic [15:0]        i16_s;
    logic [WIDTH_I-1:0] sext_s;
    logic [WIDTH_I-1:0] form_data_s;
    logic               form_err_s;
    logic               unused_s;

    assign i16_s  = instr[15:0];
    assign sext_s = {{(WIDTH_I-16){i16_s[15]}}, i16_s};
    // Only the top of pc_plus4 and the low 26 instruction bits feed any mode.
    assign unused_s = ^{instr[31:26], pc_plus4[27:0]};

    // Combinational immediate formation; LUI and BR reuse the sign-extended value
    // so the upper sign fill for WIDTH_I > 32 comes for free.
    always_comb begin
        form_data_s = '0;
        form_err_s  = 1'b0;
        case (imme_mode)
            MODE_SEXT:  form_data_s = sext_s;
            MODE_ZEXT:  form_data_s = {{(WIDTH_I-16){1'b0}}, i16_s};
            MODE_LUI:   form_data_s = sext_s << 5'd16;
            MODE_BR:    form_data_s = sext_s << 2'd2;
            MODE_JMP:   form_data_s = {pc_plus4[WIDTH_I-1:28], instr[25:0], 2'b00};
            MODE_SHAMT: form_data_s = {{(WIDTH_I-5){1'b0}}, instr[10:6]};
            default: begin
                form_data_s = '0;
                form_err_s  = 1'b1;
            end
        endcase
    end

    logic [LAT-1:0]     valid_r;
    logic [LAT-1:0]     err_r;
    logic [WIDTH_I-1:0] data_r [LAT];

    // Pipeline stages: reset clears everything, flush drops valids only (data
    // holds), stall freezes all stages, otherwise every stage shifts by one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            err_r   <= '0;
            for (int k = 0; k < LAT; k++) begin
                data_r[k] <= '0;
            end
        end else if (flush) begin
            valid_r <= '0;
        end else if (stall) begin
            valid_r <= valid_r;
            err_r   <= err_r;
            data_r  <= data_r;
        end else begin
            valid_r[0] <= in_valid;
            data_r[0]  <= form_data_s;
            err_r[0]   <= form_err_s;
            for (int k = 1; k < LAT; k++) begin
                valid_r[k] <= valid_r[k-1];
                data_r[k]  <= data_r[k-1];
                err_r[k]   <= err_r[k-1];
            end
        end
    end

    assign out_valid = valid_r[LAT-1];
    assign imme_out  = data_r[LAT-1];
    assign mode_err  = err_r[LAT-1];

endmodule

// File: tb/tb_imme_gen_pipe.sv
// Bench for imme_gen_pipe: one 32-bit LAT=1 instance and one 64-bit LAT=2
// instance, checked by a scoreboard plus per-scenario inline checks.
module tb_imme_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        in_valid1, stall1, flush1, out_valid1, mode_err1;
    logic [31:0] instr1, pc1, imme_out1;
    logic [2:0]  mode1;

    logic        in_valid2, stall2, flush2, out_valid2, mode_err2;
    logic [31:0] instr2;
    logic [63:0] pc2, imme_out2;
    logic [2:0]  mode2;

    imme_gen_pipe #(.WIDTH_I(32), .LAT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .stall(stall1), .flush(flush1),
        .instr(instr1), .pc_plus4(pc1), .imme_mode(mode1),
        .out_valid(out_valid1), .imme_out(imme_out1), .mode_err(mode_err1)
    );

    imme_gen_pipe #(.WIDTH_I(64), .LAT(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .stall(stall2), .flush(flush2),
        .instr(instr2), .pc_plus4(pc2), .imme_mode(mode2),
        .out_valid(out_valid2), .imme_out(imme_out2), .mode_err(mode_err2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] q1 [$];
    logic [64:0] q2 [$];
    logic [32:0] exp1;
    logic [64:0] exp2;

    task automatic drive1(input logic v, input logic [2:0] m, input logic [31:0] ins,
                          input logic [31:0] ed, input logic ee);
        in_valid1 = v; mode1 = m; instr1 = ins; exp1 = {ee, ed};
    endtask

    task automatic drive2(input logic v, input logic [2:0] m, input logic [31:0] ins,
                          input logic [63:0] ed, input logic ee);
        in_valid2 = v; mode2 = m; instr2 = ins; exp2 = {ee, ed};
    endtask

    // Advance one clock; push accepted inputs, pop and compare fresh outputs.
    task automatic tick;
        logic acc1, acc2;
        logic [32:0] e1;
        logic [64:0] e2;
        acc1 = !rst && !flush1 && !stall1;
        acc2 = !rst && !flush2 && !stall2;
        if (rst || flush1) q1.delete();
        else if (acc1 && in_valid1) q1.push_back(exp1);
        if (rst || flush2) q2.delete();
        else if (acc2 && in_valid2) q2.push_back(exp2);
        @(posedge clk); #1;
        if (acc1 && out_valid1) begin
            n_checks++;
            if (q1.size() == 0) begin
                n_fail++; $display("FAIL sb1_extra: got data=%h with nothing pending", imme_out1);
            end else begin
                e1 = q1.pop_front();
                if ({mode_err1, imme_out1} !== e1) begin
                    n_fail++;
                    $display("FAIL sb1_data: got err=%0b data=%h want err=%0b data=%h",
                             mode_err1, imme_out1, e1[32], e1[31:0]);
                end
            end
        end
        if (acc2 && out_valid2) begin
            n_checks++;
            if (q2.size() == 0) begin
                n_fail++; $display("FAIL sb2_extra: got data=%h with nothing pending", imme_out2);
            end else begin
                e2 = q2.pop_front();
                if ({mode_err2, imme_out2} !== e2) begin
                    n_fail++;
                    $display("FAIL sb2_data: got err=%0b data=%h want err=%0b data=%h",
                             mode_err2, imme_out2, e2[64], e2[63:0]);
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL rst_valid1: got %0b want 0", out_valid1); end
        n_checks++; if (imme_out1 !== 32'h0) begin n_fail++; $display("FAIL rst_data1: got %h want 0", imme_out1); end
        n_checks++; if (mode_err1 !== 1'b0) begin n_fail++; $display("FAIL rst_err1: got %0b want 0", mode_err1); end
        n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL rst_valid2: got %0b want 0", out_valid2); end
        n_checks++; if (imme_out2 !== 64'h0) begin n_fail++; $display("FAIL rst_data2: got %h want 0", imme_out2); end
        n_checks++; if (mode_err2 !== 1'b0) begin n_fail++; $display("FAIL rst_err2: got %0b want 0", mode_err2); end
        rst = 1'b0;
    endtask

    task automatic test_modes;
        logic [2:0]  m  [6];
        logic [31:0] in [6];
        logic [31:0] ed [6];
        m  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        in = '{32'h2408_8004, 32'h2408_8004, 32'h2408_8004, 32'h2408_8004, 32'h2408_8004, 32'h0000_0140};
        ed = '{32'hFFFF_8004, 32'h0000_8004, 32'h8004_0000, 32'hFFFE_0010, 32'hA022_0010, 32'h0000_0005};
        for (int i = 0; i < 6; i++) begin
            drive1(1'b1, m[i], in[i], ed[i], 1'b0);
            tick();
            n_checks++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL mode%0d_valid: got %0b want 1", i, out_valid1); end
            n_checks++; if (imme_out1 !== ed[i]) begin n_fail++; $display("FAIL mode%0d_data: got %h want %h", i, imme_out1, ed[i]); end
            n_checks++; if (mode_err1 !== 1'b0) begin n_fail++; $display("FAIL mode%0d_err: got %0b want 0", i, mode_err1); end
        end
        drive1(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        tick();
        n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL modes_bubble: got %0b want 0", out_valid1); end
    endtask

    task automatic test_reserved;
        drive1(1'b1, 3'd7, 32'h2408_8004, 32'h0, 1'b1);
        tick();
        n_checks++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL rsv_valid: got %0b want 1", out_valid1); end
        n_checks++; if (mode_err1 !== 1'b1) begin n_fail++; $display("FAIL rsv_err: got %0b want 1", mode_err1); end
        n_checks++; if (imme_out1 !== 32'h0) begin n_fail++; $display("FAIL rsv_data: got %h want 0", imme_out1); end
        drive1(1'b1, 3'd6, 32'hFFFF_FFFF, 32'h0, 1'b1);
        tick();
        drive1(1'b1, 3'd0, 32'h0000_0001, 32'h0000_0001, 1'b0);
        tick();
        n_checks++; if (mode_err1 !== 1'b0) begin n_fail++; $display("FAIL rsv_clear: got %0b want 0", mode_err1); end
        drive1(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        tick();
    endtask

    task automatic test_wide;
        drive2(1'b1, 3'd0, 32'h0000_8000, 64'hFFFF_FFFF_FFFF_8000, 1'b0);
        tick();
        n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL wide_early: got %0b want 0", out_valid2); end
        drive2(1'b1, 3'd2, 32'h0000_8000, 64'hFFFF_FFFF_8000_0000, 1'b0);
        tick();
        n_checks++; if (out_valid2 !== 1'b1) begin n_fail++; $display("FAIL wide_sext_valid: got %0b want 1", out_valid2); end
        n_checks++; if (imme_out2 !== 64'hFFFF_FFFF_FFFF_8000) begin n_fail++; $display("FAIL wide_sext: got %h want ffffffffffff8000", imme_out2); end
        drive2(1'b1, 3'd4, 32'h0000_0003, 64'h1234_5678_9000_000C, 1'b0);
        tick();
        n_checks++; if (imme_out2 !== 64'hFFFF_FFFF_8000_0000) begin n_fail++; $display("FAIL wide_lui: got %h want ffffffff80000000", imme_out2); end
        drive2(1'b0, 3'd0, 32'h0, 64'h0, 1'b0);
        tick();
        n_checks++; if (imme_out2 !== 64'h1234_5678_9000_000C) begin n_fail++; $display("FAIL wide_jmp: got %h want 123456789000000c", imme_out2); end
        tick();
        n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL wide_bubble: got %0b want 0", out_valid2); end
    endtask

    task automatic test_stall;
        drive1(1'b1, 3'd0, 32'h0000_1234, 32'h0000_1234, 1'b0);
        tick();
        drive1(1'b1, 3'd1, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
        tick();
        stall1 = 1'b1;
        drive1(1'b1, 3'd3, 32'h0000_0001, 32'h0000_0004, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL stall_valid%0d: got %0b want 1", i, out_valid1); end
            n_checks++; if (imme_out1 !== 32'h0000_FFFF) begin n_fail++; $display("FAIL stall_hold%0d: got %h want 0000ffff", i, imme_out1); end
        end
        stall1 = 1'b0;
        tick();
        n_checks++; if (imme_out1 !== 32'h0000_0004) begin n_fail++; $display("FAIL stall_resume: got %h want 00000004", imme_out1); end
        drive1(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        tick();
        n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL stall_dup: got %0b want 0", out_valid1); end
    endtask

    task automatic test_flush;
        drive2(1'b1, 3'd0, 32'h0000_0001, 64'h1, 1'b0);
        tick();
        drive2(1'b1, 3'd1, 32'h0000_0002, 64'h2, 1'b0);
        tick();
        n_checks++; if (out_valid2 !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got %0b want 1", out_valid2); end
        flush2 = 1'b1; stall2 = 1'b1;
        drive2(1'b1, 3'd0, 32'h0000_0003, 64'h3, 1'b0);
        tick();
        n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL flush_now: got %0b want 0", out_valid2); end
        flush2 = 1'b0; stall2 = 1'b0;
        drive2(1'b0, 3'd0, 32'h0, 64'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL flush_stay%0d: got %0b want 0", i, out_valid2); end
        end
        drive2(1'b1, 3'd5, 32'h0000_0040, 64'h1, 1'b0);
        tick();
        n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL flush_refill: got %0b want 0", out_valid2); end
        drive2(1'b0, 3'd0, 32'h0, 64'h0, 1'b0);
        tick();
        n_checks++; if (out_valid2 !== 1'b1) begin n_fail++; $display("FAIL flush_new: got %0b want 1", out_valid2); end
        tick();
    endtask

    task automatic test_async_reset;
        drive1(1'b1, 3'd0, 32'h0000_7FFF, 32'h0000_7FFF, 1'b0);
        drive2(1'b1, 3'd0, 32'h0000_7FFF, 64'h7FFF, 1'b0);
        tick();
        drive1(1'b1, 3'd1, 32'h0000_8001, 32'h0000_8001, 1'b0);
        drive2(1'b1, 3'd1, 32'h0000_8001, 64'h8001, 1'b0);
        tick();
        drive1(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        drive2(1'b0, 3'd0, 32'h0, 64'h0, 1'b0);
        n_checks++; if (out_valid2 !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got %0b want 1", out_valid2); end
        #2;
        rst = 1'b1;
        q1.delete(); q2.delete();
        #1;
        n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL arst_valid1: got %0b want 0", out_valid1); end
        n_checks++; if (imme_out1 !== 32'h0) begin n_fail++; $display("FAIL arst_data1: got %h want 0", imme_out1); end
        n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL arst_valid2: got %0b want 0", out_valid2); end
        n_checks++; if (imme_out2 !== 64'h0) begin n_fail++; $display("FAIL arst_data2: got %h want 0", imme_out2); end
        n_checks++; if (mode_err2 !== 1'b0) begin n_fail++; $display("FAIL arst_err2: got %0b want 0", mode_err2); end
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL arst_stale: got %0b want 0", out_valid2); end
        drive1(1'b1, 3'd2, 32'h0000_0001, 32'h0001_0000, 1'b0);
        tick();
        n_checks++; if (imme_out1 !== 32'h0001_0000) begin n_fail++; $display("FAIL arst_new: got %h want 00010000", imme_out1); end
        drive1(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        stall1 = 1'b0; flush1 = 1'b0; pc1 = 32'hA000_0010;
        stall2 = 1'b0; flush2 = 1'b0; pc2 = 64'h1234_5678_9000_0000;
        drive1(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        drive2(1'b0, 3'd0, 32'h0, 64'h0, 1'b0);
        test_reset();
        test_modes();
        test_reserved();
        test_wide();
        test_stall();
        test_flush();
        test_async_reset();
        n_checks++; if (q1.size() != 0) begin n_fail++; $display("FAIL sb1_leftover: got %0d pending want 0", q1.size()); end
        n_checks++; if (q2.size() != 0) begin n_fail++; $display("FAIL sb2_leftover: got %0d pending want 0", q2.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
